qoa_spi_host: RTL and testbench
===============================

# qoa_spi_host

SPI mode-0 controller that drives the SPI peripheral port of the QOA decoder (`sclk`, `mosi`, active-low chip select) and captures its MISO stream. Sits on the host/test side of the link: accepts bytes over a valid/ready handshake, serialises them MSB-first and returns received bytes plus assembled 16-bit sample words. Generates the extra idle-CS clock pulse the peripheral needs to preload its first MISO bit.

## Interface
- `CLK_DIV`, default 4: `clk` cycles per SCLK half-period (D); legal ≥1. Use ≥4 so the peripheral can synchronise each byte into its own clock domain.
- `PRELOAD`, default 1: 1 = emit one SCLK pulse with `cs_n` high before each frame.
- `clk` in 1: single clock for the block.
- `rst_n` in 1: reset, synchronous and active-low.
- `tx_data` in 8: byte to send.
- `tx_last` in 1: sampled with `tx_data`; 1 = release CS after this byte.
- `tx_valid` in 1: byte offered.
- `tx_ready` out 1: byte accepted when `tx_valid && tx_ready`.
- `cs_release` in 1: in WAIT, close the frame without sending a byte.
- `rx_byte` out 8: last received byte.
- `rx_valid` out 1: one-cycle pulse when `rx_byte` updates.
- `rx_word` out 16: {first, second} byte of each byte pair in a frame.
- `rx_word_valid` out 1: one-cycle pulse when `rx_word` updates.
- `busy` out 1: high in every state except IDLE.
- `sclk` out 1, `mosi` out 1, `cs_n` out 1: SPI pins, all registered.
- `miso` in 1: SPI data from the peripheral.

## Operation
- Reset values: `cs_n`=1, `sclk`=0, `mosi`=0, `tx_ready`=1, `busy`=0, `rx_valid`=0, `rx_word_valid`=0, `rx_byte`=0, `rx_word`=0.
- Reset applies on the next `clk` edge from any state, including mid-byte. It aborts the byte and raises `cs_n`. It emits no `rx_valid` and no `rx_word_valid`.
- States:
  - IDLE: `cs_n`=1, `tx_ready`=1. On accept, latch the shift register and the last flag. Go to PRE_HI if `PRELOAD`, else SETUP.
  - PRE_HI: `sclk`=1, `cs_n`=1, for D cycles. Then PRE_LO.
  - PRE_LO: `sclk`=0, `cs_n`=1, for D cycles. Then SETUP.
  - SETUP: `cs_n`=0, `sclk`=0, `mosi`=bit 7, for D cycles. Then HIGH.
  - HIGH: `sclk`=1 for D cycles. On the last cycle, shift `miso` into the receive register. Then LOW.
  - LOW: `sclk`=0 for D cycles. On entry, `mosi` advances to the next bit. After the 8th LOW: `rx_valid` pulses; go to HOLD if the last flag is set, else WAIT.
  - WAIT: `cs_n`=0, `sclk`=0, `tx_ready`=1. There is no timeout. On accept, go directly to HIGH with `mosi`=bit 7 of the new byte; there is no SETUP phase. On `cs_release`, go to HOLD.
  - HOLD: `cs_n`=0, `sclk`=0, for D cycles. Then `cs_n`=1 and go to IDLE.
- `tx_valid` in WAIT and `cs_release` in the same cycle: the byte is accepted and the release is ignored. Use `tx_last` to close the frame.
- `tx_ready`=0 in all other states. Bytes offered then are not accepted and must be held by the source.
- Word assembly:
  - A byte-pair toggle clears when `cs_n` rises.
  - The first byte of a pair is stored.
  - On the second byte, `rx_word` = {stored, new} and `rx_word_valid` pulses in the same cycle as `rx_valid`.
  - A trailing odd byte produces `rx_byte` only.
- `mosi` returns to 0 in IDLE.

## Timing
- `cs_n` falls on the cycle after the SETUP entry edge.
- The first rising SCLK edge is D cycles after `cs_n` falls.
- Each bit is 2D cycles. MISO is sampled 1 cycle before SCLK falls.
- Single-byte frame (`tx_last`=1): `cs_n` low for exactly 18D cycles. Accept to IDLE is 18D cycles, or 20D with `PRELOAD`.
- Back-to-back bytes with `tx_valid` held: 16D cycles per byte, plus 1 cycle in WAIT for the accept.
- `rx_valid` asserts on the cycle the 8th LOW phase ends.

## Structure
- Package `qoa_spi_pkg`:
  - state enum;
  - frame constants `BYTE_BITS`=8 and `WORD_BYTES`=2;
  - reset values of the SPI pins.
- Sub-module `spi_half_period_timer`: D-cycle down-counter. Inputs: load, enable. Output: one-cycle `tick` on the last cycle of a phase.
- The FSM, shift registers and word assembly stay in `qoa_spi_host`.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles → all outputs at the reset values listed above; `tx_ready`=1.
- D=2, `PRELOAD`=1; send 0xA5 with `tx_last`=1; peripheral model returns 0x3C → one pulse with `cs_n` high, then MOSI 1,0,1,0,0,1,0,1 at rising edges. `rx_byte`=0x3C with a `rx_valid` pulse. `cs_n` low for 36 cycles; `busy` for 40.
- Two-byte frame 0x12, 0x34 (`tx_last` on the second); peripheral presents 0xBEEF → single CS-low window, 16 rising edges, one preload pulse. `rx_valid` pulses with 0xBE, then 0xEF; `rx_word_valid` pulses with 0xBEEF.
- Stall in WAIT for 50 cycles → `cs_n`=0, `sclk`=0, `tx_ready`=1 throughout. Then pulse `cs_release` → `cs_n` rises D cycles later; no `rx_word_valid`.
- Assert `rst_n`=0 during bit 4 → next edge gives `cs_n`=1, `sclk`=0, no `rx_valid`. The next frame, 0x5A, transfers correctly.
- Hold `tx_valid` high while busy → not accepted until WAIT or IDLE. In WAIT, `tx_valid` and `cs_release` in the same cycle → the byte is sent and CS stays low.

Source files
------------

// File: rtl/qoa_spi_host_pkg.sv
// qoa_spi_pkg: shared state encoding, frame constants and SPI pin reset levels
// for the QOA SPI host.
package qoa_spi_pkg;

    typedef logic [2:0] spi_state_t;

    localparam spi_state_t ST_IDLE   = 3'd0;
    localparam spi_state_t ST_PRE_HI = 3'd1;
    localparam spi_state_t ST_PRE_LO = 3'd2;
    localparam spi_state_t ST_SETUP  = 3'd3;
    localparam spi_state_t ST_HIGH   = 3'd4;
    localparam spi_state_t ST_LOW    = 3'd5;
    localparam spi_state_t ST_WAIT   = 3'd6;
    localparam spi_state_t ST_HOLD   = 3'd7;

    localparam int BYTE_BITS  = 8;
    localparam int WORD_BYTES = 2;

    localparam logic CS_N_RST = 1'b1;
    localparam logic SCLK_RST = 1'b0;
    localparam logic MOSI_RST = 1'b0;

    // States in which the peripheral is selected.
    function automatic logic cs_active(input spi_state_t s);
        return s inside {ST_SETUP, ST_HIGH, ST_LOW, ST_WAIT, ST_HOLD};
    endfunction

    // States in which mosi carries the current shift-register MSB.
    function automatic logic bit_phase(input spi_state_t s);
        return s inside {ST_SETUP, ST_HIGH, ST_LOW};
    endfunction

endpackage

// File: rtl/qoa_spi_host_timer.sv
// spi_half_period_timer: CLK_DIV-cycle down-counter that marks the last cycle
// of each timed SPI phase and reloads itself for the next one.
module spi_half_period_timer #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic enable,
    output logic tick
);

    localparam int CW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] TOP = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = enable && cnt == '0;

    always_ff @(posedge clk) begin
        if (!rst_n || load)
            cnt <= TOP;
        else if (enable)
            cnt <= tick ? TOP : cnt - 1'b1;
    end

endmodule

// File: rtl/qoa_spi_host.sv
// qoa_spi_host: SPI mode-0 host for the QOA decoder peripheral port; bytes in over
// valid/ready, MSB-first shifting, received bytes and 16-bit sample words out.
module qoa_spi_host
    import qoa_spi_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter bit PRELOAD = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  tx_data,
    input  logic        tx_last,
    input  logic        tx_valid,
    output logic        tx_ready,
    input  logic        cs_release,
    output logic [7:0]  rx_byte,
    output logic        rx_valid,
    output logic [15:0] rx_word,
    output logic        rx_word_valid,
    output logic        busy,
    output logic        sclk,
    output logic        mosi,
    output logic        cs_n,
    input  logic        miso
);

    localparam int BW = $clog2(BYTE_BITS);

    spi_state_t state, state_nxt;
    logic [7:0] tx_sh, rx_sh, rx_first;
    logic [BW-1:0] bit_cnt;
    logic last, pair, tick, accept, byte_done;

    assign tx_ready  = state == ST_IDLE || state == ST_WAIT;
    assign busy      = state != ST_IDLE;
    assign accept    = tx_valid && tx_ready;
    assign byte_done = state == ST_LOW && tick && bit_cnt == BW'(BYTE_BITS - 1);

    spi_half_period_timer #(.CLK_DIV(CLK_DIV)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (accept),
        .enable (busy && state != ST_WAIT),
        .tick   (tick)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   state_nxt = accept ? (PRELOAD ? ST_PRE_HI : ST_SETUP) : ST_IDLE;
            ST_PRE_HI: state_nxt = tick ? ST_PRE_LO : ST_PRE_HI;
            ST_PRE_LO: state_nxt = tick ? ST_SETUP : ST_PRE_LO;
            ST_SETUP:  state_nxt = tick ? ST_HIGH : ST_SETUP;
            ST_HIGH:   state_nxt = tick ? ST_LOW : ST_HIGH;
            ST_LOW:    state_nxt = !tick ? ST_LOW : !byte_done ? ST_HIGH : last ? ST_HOLD : ST_WAIT;
            ST_WAIT:   state_nxt = accept ? ST_HIGH : cs_release ? ST_HOLD : ST_WAIT;
            ST_HOLD:   state_nxt = tick ? ST_IDLE : ST_HOLD;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Pins follow the state with one register stage, so every phase appears
    // on the wire for exactly CLK_DIV cycles, one cycle after its entry edge.
    always_ff @(posedge clk) begin
        rx_valid      <= 1'b0;
        rx_word_valid <= 1'b0;
        if (!rst_n) begin
            state    <= ST_IDLE;
            sclk     <= SCLK_RST;
            cs_n     <= CS_N_RST;
            mosi     <= MOSI_RST;
            tx_sh    <= '0;
            rx_sh    <= '0;
            rx_first <= '0;
            bit_cnt  <= '0;
            last     <= 1'b0;
            pair     <= 1'b0;
            rx_byte  <= '0;
            rx_word  <= '0;
        end else begin
            state <= state_nxt;
            sclk  <= state == ST_PRE_HI || state == ST_HIGH;
            cs_n  <= !cs_active(state);
            mosi  <= accept && state == ST_WAIT ? tx_data[7] : bit_phase(state) && tx_sh[7];
            if (accept) begin
                tx_sh <= tx_data;
                last  <= tx_last;
            end else if (state == ST_HIGH && tick) begin
                tx_sh <= {tx_sh[6:0], 1'b0};
                rx_sh <= {rx_sh[6:0], miso};
            end
            if (state == ST_LOW && tick)
                bit_cnt <= byte_done ? '0 : bit_cnt + 1'b1;
            if (state == ST_IDLE)
                pair <= 1'b0;
            if (byte_done) begin
                rx_byte  <= rx_sh;
                rx_valid <= 1'b1;
                pair     <= !pair;
                if (pair) begin
                    rx_word       <= {rx_first, rx_sh};
                    rx_word_valid <= 1'b1;
                end else begin
                    rx_first <= rx_sh;
                end
            end
        end
    end

endmodule

// File: tb/tb_qoa_spi_host.sv
// tb_qoa_spi_host: directed table-driven bench for qoa_spi_host with a mode-0
// peripheral model on miso and a pin-level monitor.
module tb_qoa_spi_host;

    localparam int D = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  tx_data;
    logic        tx_last, tx_valid, tx_ready, cs_release;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic [15:0] rx_word;
    logic        rx_word_valid, busy, sclk, mosi, cs_n, miso;

    qoa_spi_host #(.CLK_DIV(D), .PRELOAD(1'b1)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .tx_data       (tx_data),
        .tx_last       (tx_last),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .cs_release    (cs_release),
        .rx_byte       (rx_byte),
        .rx_valid      (rx_valid),
        .rx_word       (rx_word),
        .rx_word_valid (rx_word_valid),
        .busy          (busy),
        .sclk          (sclk),
        .mosi          (mosi),
        .cs_n          (cs_n),
        .miso          (miso)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [15:0] per_word = 16'h0000;
    logic        clr_req = 1'b0, clr_seen = 1'b0;
    logic        sclk_q = 1'b0, cs_q = 1'b1;
    int          pre_cnt, rise_cnt, fall_cnt, cs_low, busy_cnt, rx_n, wd_n, cs_rises;
    logic [15:0] mosi_bits, word_seen;
    logic [7:0]  rx_seen [4];

    // Peripheral drives bit 15 first and advances after each falling SCLK inside CS.
    assign miso = fall_cnt < 16 ? per_word[15 - fall_cnt] : 1'b0;

    always @(negedge clk) begin
        if (clr_req != clr_seen) begin
            clr_seen  = clr_req;
            pre_cnt   = 0;
            rise_cnt  = 0;
            fall_cnt  = 0;
            cs_low    = 0;
            busy_cnt  = 0;
            rx_n      = 0;
            wd_n      = 0;
            cs_rises  = 0;
            mosi_bits = '0;
            word_seen = '0;
            for (int i = 0; i < 4; i++) rx_seen[i] = '0;
        end
        if (sclk && !sclk_q) begin
            if (cs_n) pre_cnt++;
            else begin
                rise_cnt++;
                mosi_bits = {mosi_bits[14:0], mosi};
            end
        end
        if (!sclk && sclk_q && !cs_n) fall_cnt++;
        if (cs_n && !cs_q) cs_rises++;
        if (!cs_n) cs_low++;
        if (busy) busy_cnt++;
        if (rx_valid) begin
            if (rx_n < 4) rx_seen[rx_n] = rx_byte;
            rx_n++;
        end
        if (rx_word_valid) begin
            word_seen = rx_word;
            wd_n++;
        end
        sclk_q = sclk;
        cs_q   = cs_n;
    end

    typedef struct {
        logic [7:0]  b0, b1;
        logic        two;
        logic [15:0] per;
        logic [15:0] exp_mosi;
        logic [7:0]  exp_r0, exp_r1;
        logic [15:0] exp_word;
        int          exp_rise, exp_cs, exp_busy, exp_rx, exp_wd;
    } vec_t;

    vec_t vecs [4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic clr_mon();
        clr_req = !clr_req;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic offer(input logic [7:0] d, input logic l);
        bit ok = 1'b0;
        tx_data  = d;
        tx_last  = l;
        tx_valid = 1'b1;
        for (int i = 0; i < 400 && !ok; i++) begin
            ok = tx_ready;
            @(negedge clk);
        end
        tx_valid = 1'b0;
        chk("accept", 32'(ok), 32'd1);
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 600 && !ok; i++) begin
            @(negedge clk);
            ok = !busy && cs_n;
        end
        @(negedge clk);
        chk("reach_idle", 32'(ok), 32'd1);
    endtask

    task automatic wait_wait();
        bit ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            ok = tx_ready && busy;
        end
        chk("reach_wait", 32'(ok), 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, bad;
        bit ok;
        rst_n      = 1'b0;
        tx_data    = '0;
        tx_last    = 1'b0;
        tx_valid   = 1'b0;
        cs_release = 1'b0;

        // D=2: 1-byte frame CS low 18D=36, busy 20D=40; 2-byte back-to-back 2+32+1+32+2=69, busy 73.
        vecs[0] = '{8'h5A, 8'h00, 1'b0, 16'h8100, 16'h005A, 8'h81, 8'h00, 16'h0000, 8, 36, 40, 1, 0};
        vecs[1] = '{8'hA5, 8'h00, 1'b0, 16'h3C00, 16'h00A5, 8'h3C, 8'h00, 16'h0000, 8, 36, 40, 1, 0};
        vecs[2] = '{8'h12, 8'h34, 1'b1, 16'hBEEF, 16'h1234, 8'hBE, 8'hEF, 16'hBEEF, 16, 69, 73, 2, 1};
        vecs[3] = '{8'hFF, 8'h00, 1'b1, 16'h0180, 16'hFF00, 8'h01, 8'h80, 16'h0180, 16, 69, 73, 2, 1};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cs_n", 32'(cs_n), 32'd1);
        chk("rst_sclk", 32'(sclk), 32'd0);
        chk("rst_mosi", 32'(mosi), 32'd0);
        chk("rst_tx_ready", 32'(tx_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rx_valid", 32'(rx_valid), 32'd0);
        chk("rst_rx_word_valid", 32'(rx_word_valid), 32'd0);
        chk("rst_rx_byte", 32'(rx_byte), 32'd0);
        chk("rst_rx_word", 32'(rx_word), 32'd0);
        rst_n = 1'b1;
        clr_mon();

        // Reset during bit 4 aborts the byte with no receive pulse.
        per_word = 16'h3C00;
        offer(8'hA5, 1'b1);
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            ok = rise_cnt >= 4;
        end
        chk("reach_bit4", 32'(ok), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_cs_n", 32'(cs_n), 32'd1);
        chk("midrst_sclk", 32'(sclk), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("midrst_rx_n", 32'(rx_n), 32'd0);
        chk("midrst_tx_ready", 32'(tx_ready), 32'd1);

        for (int v = 0; v < 4; v++) begin
            clr_mon();
            per_word = vecs[v].per;
            offer(vecs[v].b0, !vecs[v].two);
            if (vecs[v].two) offer(vecs[v].b1, 1'b1);
            wait_idle();
            chk($sformatf("v%0d_mosi", v), 32'(mosi_bits), 32'(vecs[v].exp_mosi));
            chk($sformatf("v%0d_preload", v), 32'(pre_cnt), 32'd1);
            chk($sformatf("v%0d_rises", v), 32'(rise_cnt), 32'(vecs[v].exp_rise));
            chk($sformatf("v%0d_cs_low", v), 32'(cs_low), 32'(vecs[v].exp_cs));
            chk($sformatf("v%0d_cs_windows", v), 32'(cs_rises), 32'd1);
            chk($sformatf("v%0d_busy", v), 32'(busy_cnt), 32'(vecs[v].exp_busy));
            chk($sformatf("v%0d_rx_n", v), 32'(rx_n), 32'(vecs[v].exp_rx));
            chk($sformatf("v%0d_rx0", v), 32'(rx_seen[0]), 32'(vecs[v].exp_r0));
            chk($sformatf("v%0d_rx1", v), 32'(rx_seen[1]), 32'(vecs[v].exp_r1));
            chk($sformatf("v%0d_wd_n", v), 32'(wd_n), 32'(vecs[v].exp_wd));
            chk($sformatf("v%0d_word", v), 32'(word_seen), 32'(vecs[v].exp_word));
            chk($sformatf("v%0d_idle_mosi", v), 32'(mosi), 32'd0);
        end

        // Stall in WAIT, then close the frame with cs_release.
        clr_mon();
        per_word = 16'hBEEF;
        offer(8'h12, 1'b0);
        wait_wait();
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            if (cs_n !== 1'b0 || sclk !== 1'b0 || tx_ready !== 1'b1) bad++;
            @(negedge clk);
        end
        chk("stall_bad_cycles", 32'(bad), 32'd0);
        cs_release = 1'b1;
        @(negedge clk);
        cs_release = 1'b0;
        k = 0;
        while (!cs_n && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("release_delay_ok", 32'(k >= D && k <= D + 1), 32'd1);
        wait_idle();
        chk("release_rx_n", 32'(rx_n), 32'd1);
        chk("release_rx0", 32'(rx_seen[0]), 32'hBE);
        chk("release_wd_n", 32'(wd_n), 32'd0);

        // tx_valid and cs_release together in WAIT: byte wins, CS stays low.
        clr_mon();
        per_word = 16'hBEEF;
        offer(8'h12, 1'b0);
        wait_wait();
        tx_data    = 8'h34;
        tx_last    = 1'b1;
        tx_valid   = 1'b1;
        cs_release = 1'b1;
        @(negedge clk);
        tx_valid   = 1'b0;
        cs_release = 1'b0;
        wait_idle();
        chk("both_mosi", 32'(mosi_bits), 32'h1234);
        chk("both_cs_windows", 32'(cs_rises), 32'd1);
        chk("both_cs_low", 32'(cs_low), 32'd69);
        chk("both_wd_n", 32'(wd_n), 32'd1);
        chk("both_word", 32'(word_seen), 32'hBEEF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
